// File: rtl/buscaminas_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | buscaminas_pkg                                                     |
// | Board geometry, cell layout, reveal FSM states, neighbour offsets. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package buscaminas_pkg;

   localparam int N       = 8;
   localparam int CELL_AW = $clog2(N*N);
   localparam int CELL_CW = $clog2(N);

   localparam int BOMBA    = 6;
   localparam int REVELADA = 5;
   localparam int BANDERA  = 4;
   localparam int ADJ_MSB  = 3;
   localparam int ADJ_LSB  = 0;

   typedef logic [CELL_AW-1:0] cell_addr_t;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RD_ORIGIN  = 3'd1,
      CHK_ORIGIN = 3'd2,
      POP        = 3'd3,
      NB_RD      = 3'd4,
      NB_CHK     = 3'd5,
      FIN        = 3'd6
   } state_t;

   // Two's-complement row/column deltas, k = 0..7 in raster order around the centre
   localparam logic [1:0] OFF_I [8] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
   localparam logic [1:0] OFF_J [8] = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01};

   // N is a power of two, so i*N + j is plain concatenation
   function automatic cell_addr_t cell_addr(input logic [CELL_CW-1:0] i,
                                            input logic [CELL_CW-1:0] j);
      return {i, j};
   endfunction

endpackage
`default_nettype wire

// File: rtl/pila_lifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pila_lifo                                                          |
// | Register-array LIFO with combinational top-of-stack.               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pila_lifo #(
   parameter int DEPTH = 64,
   parameter int DW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] push_data,
   output logic [DW-1:0] top,
   output logic          empty
);

   localparam int IW  = $clog2(DEPTH);
   localparam int SPW = $clog2(DEPTH + 1);

   logic [DW-1:0]  r_mem [DEPTH];
   logic [SPW-1:0] r_sp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sp <= '0;
      end else if (push) begin
         r_sp <= r_sp + 1'b1;
      end else if (pop && (r_sp != '0)) begin
         r_sp <= r_sp - 1'b1;
      end
   end

   // Storage needs no reset: the pointer alone defines which entries are live
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[IW'(r_sp)] <= push_data;
      end
   end

   assign empty = (r_sp == '0);
   assign top   = r_mem[IW'(r_sp - 1'b1)];

endmodule
`default_nettype wire

// File: rtl/buscaminas_revelador.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | buscaminas_revelador                                               |
// | Flood-fill reveal controller driving the board RAM ports.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module buscaminas_revelador
   import buscaminas_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [2:0]              start_i,
   input  logic [2:0]              start_j,
   output logic [$clog2(N*N)-1:0]  rd_addr,
   input  logic [6:0]              rd_data,
   output logic                    we,
   output logic [$clog2(N*N)-1:0]  wr_addr,
   output logic [6:0]              wr_data,
   output logic                    busy,
   output logic                    done,
   output logic                    hit_bomb,
   output logic [6:0]              revealed_count
);

   localparam int AW = $clog2(N*N);
   localparam int CW = $clog2(N);

   state_t          r_state, w_next;
   logic [CW-1:0]   r_oi, r_oj, r_ci, r_cj;
   logic [2:0]      r_k;

   logic            w_latch, w_load, w_k_adv, w_inc, w_set_bomb;
   logic            w_push, w_pop, w_empty;
   logic [AW-1:0]   w_push_data, w_top;
   logic [AW-1:0]   w_origin_addr, w_nb_addr;
   logic [CW+1:0]   w_ni, w_nj;
   logic            w_nb_in, w_last_k, w_free;
   logic [1:0]      w_di, w_dj;

   assign w_origin_addr = cell_addr(r_oi, r_oj);
   assign w_di          = OFF_I[r_k];
   assign w_dj          = OFF_J[r_k];
   assign w_ni          = {2'b00, r_ci} + {{CW{w_di[1]}}, w_di};
   assign w_nj          = {2'b00, r_cj} + {{CW{w_dj[1]}}, w_dj};
   // -1 wraps into the top bit and N sets bit CW, so both upper bits clear means on-board
   assign w_nb_in       = (w_ni[CW+1:CW] == 2'b00) && (w_nj[CW+1:CW] == 2'b00);
   assign w_nb_addr     = cell_addr(w_ni[CW-1:0], w_nj[CW-1:0]);
   assign w_last_k      = (r_k == 3'd7);
   assign w_free        = !rd_data[REVELADA] && !rd_data[BANDERA] && !rd_data[BOMBA];
   assign busy          = (r_state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      rd_addr     = '0;
      we          = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      done        = 1'b0;
      w_latch     = 1'b0;
      w_load      = 1'b0;
      w_k_adv     = 1'b0;
      w_inc       = 1'b0;
      w_set_bomb  = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_push_data = '0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_latch = 1'b1;
               w_next  = RD_ORIGIN;
            end
         end
         RD_ORIGIN: begin
            rd_addr = w_origin_addr;
            w_next  = CHK_ORIGIN;
         end
         CHK_ORIGIN: begin
            w_next = FIN;
            if (!rd_data[REVELADA] && !rd_data[BANDERA]) begin
               we                = 1'b1;
               wr_addr           = w_origin_addr;
               wr_data           = rd_data;
               wr_data[REVELADA] = 1'b1;
               w_inc             = 1'b1;
               if (rd_data[BOMBA]) begin
                  w_set_bomb = 1'b1;
               end else if (rd_data[ADJ_MSB:ADJ_LSB] == 4'd0) begin
                  w_push      = 1'b1;
                  w_push_data = w_origin_addr;
                  w_next      = POP;
               end
            end
         end
         POP: begin
            if (w_empty) begin
               w_next = FIN;
            end else begin
               w_pop  = 1'b1;
               w_load = 1'b1;
               w_next = NB_RD;
            end
         end
         NB_RD: begin
            if (w_nb_in) begin
               rd_addr = w_nb_addr;
               w_next  = NB_CHK;
            end else if (w_last_k) begin
               w_next = POP;
            end else begin
               w_k_adv = 1'b1;
            end
         end
         NB_CHK: begin
            if (w_free) begin
               we                = 1'b1;
               wr_addr           = w_nb_addr;
               wr_data           = rd_data;
               wr_data[REVELADA] = 1'b1;
               w_inc             = 1'b1;
               if (rd_data[ADJ_MSB:ADJ_LSB] == 4'd0) begin
                  w_push      = 1'b1;
                  w_push_data = w_nb_addr;
               end
            end
            if (w_last_k) begin
               w_next = POP;
            end else begin
               w_k_adv = 1'b1;
               w_next  = NB_RD;
            end
         end
         FIN: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_oi           <= '0;
         r_oj           <= '0;
         r_ci           <= '0;
         r_cj           <= '0;
         r_k            <= '0;
         hit_bomb       <= 1'b0;
         revealed_count <= '0;
      end else begin
         if (w_latch) begin
            r_oi           <= start_i;
            r_oj           <= start_j;
            hit_bomb       <= 1'b0;
            revealed_count <= '0;
         end
         if (w_set_bomb) begin
            hit_bomb <= 1'b1;
         end
         if (w_inc) begin
            revealed_count <= revealed_count + 7'd1;
         end
         if (w_load) begin
            r_ci <= w_top[AW-1:CW];
            r_cj <= w_top[CW-1:0];
            r_k  <= '0;
         end else if (w_k_adv) begin
            r_k <= r_k + 3'd1;
         end
      end
   end

   pila_lifo #(
      .DEPTH (N*N),
      .DW    (AW)
   ) u_pila (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (w_push_data),
      .top       (w_top),
      .empty     (w_empty)
   );

endmodule
`default_nettype wire

// File: doc/buscaminas_revelador.md
# buscaminas_revelador

Flood-fill reveal controller for the 8x8 minesweeper board. When a cell is selected, it sequences all reads and writes to the board RAM: it reveals the chosen cell and, if that cell has zero adjacent bombs, iteratively reveals the connected zero region and its numbered border. It sits between the game FSM, which issues start on cell selection, and the board storage, which exposes one synchronous read port and one write port.

## Interface
Parameters:
- N, 8, board side; the board has N*N cells, address = i*N + j, AW = $clog2(N*N).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a reveal; sampled only in IDLE.
- start_i, start_j  in  3  row and column of the selected cell.
- rd_addr  out  AW  board read address.
- rd_data  in  7  board cell, valid one cycle after rd_addr.
- we  out  1  board write strobe.
- wr_addr  out  AW  write address.
- wr_data  out  7  write data.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of an operation.
- hit_bomb  out  1  origin was a bomb; held until the next accepted start.
- revealed_count  out  7  cells newly revealed by the last operation; held until the next accepted start.

## Operation
- Cell format:
  - [6] bomb.
  - [5] revealed.
  - [4] flag.
  - [3:0] adjacent-bomb count, 0-8.
- States: IDLE, RD_ORIGIN, CHK_ORIGIN, POP, NB_RD, NB_CHK, FIN.
- IDLE: on start, latch the origin, clear hit_bomb and revealed_count, and go to RD_ORIGIN.
- RD_ORIGIN: drive rd_addr = origin, then go to CHK_ORIGIN.
- CHK_ORIGIN:
  - If revealed or flag is set: no write; go to FIN.
  - Else: write the cell with [5]=1 and count = 1.
  - If bomb: set hit_bomb and go to FIN.
  - Else if adj == 0: push the origin and go to POP.
  - Else: go to FIN.
- POP: if the stack is empty, go to FIN. Otherwise pop the centre cell, set k=0, and go to NB_RD.
- NB_RD:
  - Neighbour order k = 0..7: (-1,-1), (-1,0), (-1,+1), (0,-1), (0,+1), (+1,-1), (+1,0), (+1,+1).
  - Out-of-bounds neighbour: skip without a read; advance k (or go to POP after k=7) in the same cycle.
  - In-bounds neighbour: drive rd_addr and go to NB_CHK.
- NB_CHK:
  - If the neighbour has revealed, flag and bomb all clear: write it with [5]=1 and count+1.
  - If that neighbour also has adj == 0: push it.
  - Then advance k; after k=7 go to POP.
- FIN: assert done and go to IDLE.
- Each cell is pushed at most once, because it is marked revealed at push time. The stack therefore never exceeds N*N entries and overflow is impossible.
- wr_data preserves bits [6], [4] and [3:0] of the value read and sets only [5].
- start while busy is ignored.

## Timing
- Reset values:
  - state IDLE, stack empty.
  - busy, done, we, hit_bomb = 0.
  - revealed_count = 0.
  - rd_addr, wr_addr, wr_data = 0.
- Single-cell operation (start sampled at edge T):
  - rd_addr valid in cycle T+1.
  - we asserted in T+2.
  - done in T+3.
- Flood fill: 2 cycles per in-bounds neighbour, 1 cycle per out-of-bounds neighbour, plus 1 cycle per POP.
- Writes are single-cycle; wr_addr and wr_data are valid only when we = 1.
- rst low at any time: immediate return to IDLE, stack emptied, we deasserted. No further writes occur. Board contents are untouched by this block.

## Structure
- buscaminas_pkg:
  - N.
  - Cell bit-position constants: BOMBA=6, REVELADA=5, BANDERA=4, ADJ=3:0.
  - Cell address typedef.
  - State enum.
  - Neighbour offset table.
- Sub-module pila_lifo: 64 x AW LIFO with push, pop, empty; same clk/rst. Push and pop are never simultaneous.

## Test plan
- Origin (2,5) = 7'b0000011 -> one write 7'b0100011 to addr 21; done at T+3; revealed_count = 1; hit_bomb = 0.
- Origin (0,0) = 7'b1000000 -> write 7'b1100000; hit_bomb = 1; revealed_count = 1; no further writes.
- Board with no bombs, all zeros, start (0,0) -> all 64 cells written with [5]=1, each exactly once; revealed_count = 64; no out-of-range address ever driven.
- Flagged origin 7'b0010000, and separately an already-revealed origin -> no we; done at T+3; revealed_count = 0.
- Zero region around (7,7) with a flagged neighbour and a bomb at (5,5) -> flagged and bomb cells are never written; numbered border cells are revealed but not expanded.
- rst pulled low mid-fill -> busy, we and done go low immediately; after release the block stays IDLE until a new start.
